// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, ALU (A) and load (B)
// write ports, per-register load scoreboard and a registered debug read port.
module regfile_mp #(
  parameter int XLEN     = 16,
  parameter int NREG     = 16,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_a,
  input  logic [AW-1:0]       wa_a,
  input  logic [XLEN-1:0]     wd_a,
  input  logic                we_b,
  input  logic [AW-1:0]       wa_b,
  input  logic [XLEN-1:0]     wd_b,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic                set_busy,
  input  logic [AW-1:0]       set_addr,
  output logic [NREG-1:0]     busy_vec,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0] reg_val [NREG];
  logic [NREG-1:0] busy_q;
  logic [XLEN-1:0] dbg_data_reg;

  // Storage and scoreboard, one slice per register.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign reg_val[gi] = '0;
        assign busy_q[gi]  = 1'b0;
      end else begin : g_live
        localparam logic [AW-1:0] IDX = AW'(gi);
        logic            wsel_a;
        logic            wsel_b;
        logic            set_hit;
        logic [XLEN-1:0] val_reg;
        logic [XLEN-1:0] val_next;
        logic            busy_reg;
        logic            busy_next;

        assign wsel_a  = we_a && (wa_a == IDX);
        assign wsel_b  = we_b && (wa_b == IDX);
        assign set_hit = set_busy && (set_addr == IDX);

        // Port B has priority over port A on an address collision; a new
        // load issue outranks the completing load's clear.
        always_comb begin
          val_next  = val_reg;
          busy_next = busy_reg;
          if (wsel_b) begin
            val_next  = wd_b;
            busy_next = 1'b0;
          end else if (wsel_a) begin
            val_next = wd_a;
          end
          if (set_hit) begin
            busy_next = 1'b1;
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            val_reg  <= '0;
            busy_reg <= 1'b0;
          end else begin
            val_reg  <= val_next;
            busy_reg <= busy_next;
          end
        end

        assign reg_val[gi] = val_reg;
        assign busy_q[gi]  = busy_reg;
      end
    end
  endgenerate

  assign busy_vec = busy_q;

  // Read ports: stored value, optionally overridden by same-cycle write data.
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign addr = ra[gi*AW +: AW];

      always_comb begin
        data = reg_val[addr];
        bsy  = busy_q[addr];
        if (BYPASS != 0) begin
          if (we_b && (wa_b == addr)) begin
            data = wd_b;
            bsy  = 1'b0;
          end else if (we_a && (wa_a == addr)) begin
            data = wd_a;
          end
        end
        if (ZERO_REG != 0 && addr == '0) begin
          data = '0;
        end
      end

      assign rd[gi*XLEN +: XLEN] = data;
      assign rd_busy[gi]         = bsy;
    end
  endgenerate

  // Debug port sees the pre-edge contents only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_data_reg <= '0;
    end else begin
      dbg_data_reg <= reg_val[dbg_addr];
    end
  end

  assign dbg_data = dbg_data_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one non-bypassing
// instance driven by the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_a, we_b, set_busy;
  logic [3:0]  wa_a, wa_b, set_addr, dbg_addr;
  logic [15:0] wd_a, wd_b;
  logic [7:0]  ra;
  logic [31:0] rd, rd_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [15:0] busy_vec, busy_vec_nb;
  logic [15:0] dbg_data, dbg_data_nb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(16), .NREG(16), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .set_busy(set_busy), .set_addr(set_addr), .busy_vec(busy_vec),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_mp #(.XLEN(16), .NREG(16), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra(ra), .rd(rd_nb), .rd_busy(rd_busy_nb),
    .set_busy(set_busy), .set_addr(set_addr), .busy_vec(busy_vec_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  task automatic idle();
    we_a = 1'b0; wa_a = '0; wd_a = '0;
    we_b = 1'b0; wa_b = '0; wd_b = '0;
    set_busy = 1'b0; set_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    $display("[%0t] reset: scan all registers on both ports", $time);
    for (int r = 0; r < 16; r++) begin
      ra = {4'(r), 4'(r)};
      #1;
      n_cmp++;
      if (rd !== 32'h0 || rd_nb !== 32'h0 || rd_busy !== 2'b00) begin
        n_err++;
        $display("FAIL reset_rd r%0d: got rd=%h rd_nb=%h busy=%b want 0/0/00", r, rd, rd_nb, rd_busy);
      end
    end
    n_cmp++;
    if (busy_vec !== 16'h0 || dbg_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: got busy_vec=%h dbg=%h want 0000/0000", busy_vec, dbg_data);
    end
  endtask

  task automatic test_bypass();
    $display("[%0t] write A r3=1234, read r3 same cycle", $time);
    we_a = 1'b1; wa_a = 4'd3; wd_a = 16'h1234; ra = {4'd3, 4'd3};
    #1;
    n_cmp++;
    if (rd !== 32'h1234_1234) begin
      n_err++;
      $display("FAIL bypass_a: got %h want 12341234", rd);
    end
    n_cmp++;
    if (rd_nb[15:0] !== 16'h0000) begin
      n_err++;
      $display("FAIL nobypass_same: got %h want 0000", rd_nb[15:0]);
    end
    tick();
    ra = {4'd3, 4'd3};
    #1;
    n_cmp++;
    if (rd_nb[15:0] !== 16'h1234 || rd[15:0] !== 16'h1234) begin
      n_err++;
      $display("FAIL stored_r3: got nb=%h byp=%h want 1234", rd_nb[15:0], rd[15:0]);
    end
  endtask

  task automatic test_collision();
    $display("[%0t] write A r5=AAAA and B r5=5555 same cycle", $time);
    we_a = 1'b1; wa_a = 4'd5; wd_a = 16'hAAAA;
    we_b = 1'b1; wa_b = 4'd5; wd_b = 16'h5555;
    ra = {4'd0, 4'd5}; dbg_addr = 4'd5;
    #1;
    n_cmp++;
    if (rd[15:0] !== 16'h5555) begin
      n_err++;
      $display("FAIL collide_bypass: got %h want 5555", rd[15:0]);
    end
    tick();
    #1;
    n_cmp++;
    if (rd[15:0] !== 16'h5555 || rd_nb[15:0] !== 16'h5555) begin
      n_err++;
      $display("FAIL collide_stored: got byp=%h nb=%h want 5555", rd[15:0], rd_nb[15:0]);
    end
    n_cmp++;
    if (dbg_data !== 16'h0000) begin
      n_err++;
      $display("FAIL dbg_prewrite: got %h want 0000", dbg_data);
    end
    tick();
    n_cmp++;
    if (dbg_data !== 16'h5555) begin
      n_err++;
      $display("FAIL dbg_r5: got %h want 5555", dbg_data);
    end
  endtask

  task automatic test_zero_reg();
    $display("[%0t] write A r0=FFFF", $time);
    we_a = 1'b1; wa_a = 4'd0; wd_a = 16'hFFFF; ra = {4'd0, 4'd0};
    #1;
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL zero_bypass_a: got %h want 0", rd);
    end
    tick();
    $display("[%0t] write B r0=FFFF with set_busy r0", $time);
    we_b = 1'b1; wa_b = 4'd0; wd_b = 16'hFFFF; set_busy = 1'b1; set_addr = 4'd0;
    #1;
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL zero_bypass_b: got %h want 0", rd);
    end
    tick();
    #1;
    n_cmp++;
    if (rd !== 32'h0 || rd_nb !== 32'h0) begin
      n_err++;
      $display("FAIL zero_stored: got byp=%h nb=%h want 0", rd, rd_nb);
    end
    n_cmp++;
    if (busy_vec !== 16'h0 || rd_busy !== 2'b00) begin
      n_err++;
      $display("FAIL zero_busy: got vec=%h rd_busy=%b want 0000/00", busy_vec, rd_busy);
    end
  endtask

  task automatic test_busy();
    $display("[%0t] set_busy r7", $time);
    set_busy = 1'b1; set_addr = 4'd7;
    tick();
    ra = {4'd7, 4'd7};
    #1;
    n_cmp++;
    if (busy_vec !== 16'h0080 || rd_busy !== 2'b11 || rd_busy_nb !== 2'b11) begin
      n_err++;
      $display("FAIL busy_set: got vec=%h rb=%b rb_nb=%b want 0080/11/11", busy_vec, rd_busy, rd_busy_nb);
    end
    $display("[%0t] write A r7=7777 and set_busy r7 again", $time);
    we_a = 1'b1; wa_a = 4'd7; wd_a = 16'h7777; set_busy = 1'b1; set_addr = 4'd7;
    tick();
    n_cmp++;
    if (busy_vec !== 16'h0080) begin
      n_err++;
      $display("FAIL busy_hold: got %h want 0080", busy_vec);
    end
    $display("[%0t] write B r7=00C0", $time);
    we_b = 1'b1; wa_b = 4'd7; wd_b = 16'h00C0;
    #1;
    n_cmp++;
    if (rd !== 32'h00C0_00C0 || rd_busy !== 2'b00) begin
      n_err++;
      $display("FAIL busy_fwd: got rd=%h rb=%b want 00C000C0/00", rd, rd_busy);
    end
    n_cmp++;
    if (rd_nb[15:0] !== 16'h7777 || rd_busy_nb !== 2'b11 || busy_vec !== 16'h0080) begin
      n_err++;
      $display("FAIL busy_nofwd: got rd=%h rb=%b vec=%h want 7777/11/0080", rd_nb[15:0], rd_busy_nb, busy_vec);
    end
    tick();
    n_cmp++;
    if (busy_vec !== 16'h0000 || rd[15:0] !== 16'h00C0) begin
      n_err++;
      $display("FAIL busy_clear: got vec=%h rd=%h want 0000/00C0", busy_vec, rd[15:0]);
    end
    $display("[%0t] set_busy r7 and write B r7=0111 same cycle", $time);
    set_busy = 1'b1; set_addr = 4'd7; we_b = 1'b1; wa_b = 4'd7; wd_b = 16'h0111;
    tick();
    n_cmp++;
    if (busy_vec !== 16'h0080 || rd_nb[15:0] !== 16'h0111) begin
      n_err++;
      $display("FAIL busy_setwins: got vec=%h rd=%h want 0080/0111", busy_vec, rd_nb[15:0]);
    end
    we_b = 1'b1; wa_b = 4'd7; wd_b = 16'h0111;
    tick();
  endtask

  task automatic test_back_to_back();
    $display("[%0t] write A r1=1111", $time);
    we_a = 1'b1; wa_a = 4'd1; wd_a = 16'h1111;
    tick();
    $display("[%0t] write A r2=2222 and B r1=3333", $time);
    we_a = 1'b1; wa_a = 4'd2; wd_a = 16'h2222;
    we_b = 1'b1; wa_b = 4'd1; wd_b = 16'h3333;
    ra = {4'd2, 4'd1};
    #1;
    n_cmp++;
    if (rd !== 32'h2222_3333) begin
      n_err++;
      $display("FAIL b2b_bypass: got %h want 22223333", rd);
    end
    n_cmp++;
    if (rd_nb !== 32'h0000_1111) begin
      n_err++;
      $display("FAIL b2b_nobypass: got %h want 00001111", rd_nb);
    end
    tick();
    #1;
    n_cmp++;
    if (rd !== 32'h2222_3333 || rd_nb !== 32'h2222_3333) begin
      n_err++;
      $display("FAIL b2b_stored: got byp=%h nb=%h want 22223333", rd, rd_nb);
    end
  endtask

  task automatic test_async_reset();
    $display("[%0t] write A r4=0042 with set_busy r4", $time);
    we_a = 1'b1; wa_a = 4'd4; wd_a = 16'h0042; set_busy = 1'b1; set_addr = 4'd4;
    ra = {4'd4, 4'd4}; dbg_addr = 4'd4;
    tick();
    tick();
    n_cmp++;
    if (rd[15:0] !== 16'h0042 || busy_vec[4] !== 1'b1 || dbg_data !== 16'h0042) begin
      n_err++;
      $display("FAIL pre_reset: got rd=%h vec=%h dbg=%h want 0042/0010/0042", rd[15:0], busy_vec, dbg_data);
    end
    $display("[%0t] assert rst between edges with write A r4=0099", $time);
    #2;
    rst = 1'b1;
    we_a = 1'b1; wa_a = 4'd4; wd_a = 16'h0099; set_busy = 1'b1; set_addr = 4'd4;
    #1;
    we_a = 1'b0;
    #1;
    n_cmp++;
    if (rd_nb !== 32'h0 || busy_vec !== 16'h0 || dbg_data !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset: got rd=%h vec=%h dbg=%h want 0/0000/0000", rd_nb, busy_vec, dbg_data);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (dbg_data !== 16'h0 || rd !== 32'h0 || busy_vec !== 16'h0) begin
      n_err++;
      $display("FAIL post_reset: got dbg=%h rd=%h vec=%h want 0000/0/0000", dbg_data, rd, busy_vec);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ra = '0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    test_reset();
    test_bypass();
    test_collision();
    test_zero_reg();
    test_busy();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
